// File: rtl/hash_sched_pkg.sv
// rtl/hash_sched_pkg.sv - shared types, constants and round-robin helper for hash_req_sched
package hash_sched_pkg;

    localparam int KEY_W   = 64;
    localparam int DEF_LAT = 11;

    typedef enum logic [0:0] {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } sched_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/hash_req_sched_if.sv
// rtl/hash_req_sched_if.sv - requester, hash pipeline and response signals of hash_req_sched
interface hash_req_sched_if
    import hash_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 15
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*KEY_W-1:0] req_key;
    logic [NREQ-1:0]       req_ready;
    logic                  mh_ce;
    logic [KEY_W-1:0]      mh_a;
    logic                  mh_in_v;
    logic [NBITS-1:0]      mh_p;
    logic                  mh_out_v;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [NBITS-1:0]      rsp_hash;
    logic                  rsp_ready;

    // scheduler side
    modport slave (
        input  req_valid, req_key, mh_p, mh_out_v, rsp_ready,
        output req_ready, mh_ce, mh_a, mh_in_v, rsp_valid, rsp_id, rsp_hash
    );

    // requesters, hash pipeline and consumer side
    modport master (
        output req_valid, req_key, mh_p, mh_out_v, rsp_ready,
        input  req_ready, mh_ce, mh_a, mh_in_v, rsp_valid, rsp_id, rsp_hash
    );

endinterface

// File: rtl/hash_req_sched_rr_arbiter.sv
// rtl/hash_req_sched_rr_arbiter.sv - combinational round-robin arbiter, one-hot grant starting at ptr
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hash_req_sched.sv
// rtl/hash_req_sched.sv - round-robin scheduler sharing one mul_hash pipeline among NREQ requesters
// Optional per-requester grant and stall counters when HASH_SCHED_STATS_EN is defined.
module hash_req_sched
    import hash_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 15,
    parameter int LAT   = DEF_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    hash_req_sched_if.slave      bus
`ifdef HASH_SCHED_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [NREQ*32-1:0]   stat_grants,
    output logic [31:0]          stat_stall
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int FCW = $clog2(LAT + 2);

    sched_state_t     state, state_nxt;
    logic [FCW-1:0]   flush_cnt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   tag_pipe [LAT];
    logic             stall, ce, grant_en, rsp_valid_c;
    logic [NREQ-1:0]  arb_req, grant;
    logic [IDW-1:0]   grant_id;
    logic [KEY_W-1:0] grant_key;
    logic [NBITS-1:0] hash_c;

    // state register and flush counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FLUSH;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= (state == FLUSH) ? flush_cnt + FCW'(1) : '0;
        end
    end

    // the pipeline has no reset; LAT+1 enabled idle cycles push out any stale valids
    always_comb begin
        state_nxt = state;
        if (state == FLUSH && flush_cnt == FCW'(LAT)) begin
            state_nxt = RUN;
        end
    end

    always_comb begin
        stall       = 1'b0;
        ce          = 1'b1;
        grant_en    = 1'b0;
        rsp_valid_c = 1'b0;
        if (state == RUN) begin
            stall       = bus.mh_out_v & ~bus.rsp_ready;
            ce          = ~stall;
            grant_en    = ~stall;
            rsp_valid_c = bus.mh_out_v;
        end
    end

    assign arb_req = grant_en ? bus.req_valid : '0;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        grant_id  = '0;
        grant_key = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_id  = IDW'(i);
                grant_key = bus.req_key[KEY_W*i +: KEY_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= IDW'(rr_next(int'(grant_id), NREQ));
        end
    end

    // tag pipe advances in lockstep with the hash pipeline so its tail lines up with mh_out_v
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else if (ce) begin
            tag_pipe[0] <= grant_id;
            for (int i = 1; i < LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign hash_c        = bus.mh_p;
    assign bus.req_ready = grant;
    assign bus.mh_ce     = ce;
    assign bus.mh_a      = grant_key;
    assign bus.mh_in_v   = |grant;
    assign bus.rsp_valid = rsp_valid_c;
    assign bus.rsp_id    = tag_pipe[LAT-1];
    assign bus.rsp_hash  = hash_c;

`ifdef HASH_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else if (stat_clr) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && stat_grants[32*i +: 32] != 32'hFFFF_FFFF) begin
                    stat_grants[32*i +: 32] <= stat_grants[32*i +: 32] + 32'd1;
                end
            end
            if (stall && stat_stall != 32'hFFFF_FFFF) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
